// File: rtl/fifo_unpacker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_unpacker
//   Drain stage for the word fifo. Pops one DATA_WIDTH word at a time and
//   replays it as DATA_WIDTH/OUT_WIDTH beats on a valid/ready stream, least
//   significant chunk first. The final beat of every word carries out_last and
//   a running count of fully delivered words is kept in word_cnt.
//
// Ports
//   clk        clock, all logic on the rising edge
//   arst_n     asynchronous active-low reset
//   srst       synchronous active-high clear (drops any partial word)
//   fifo_mty   fifo empty flag
//   fifo_q     fifo read data, valid the cycle after fifo_rd
//   fifo_rd    fifo pop strobe (combinational)
//   out_data   beat data
//   out_valid  beat valid
//   out_last   final beat of the current word
//   out_ready  consumer ready; a beat moves when out_valid & out_ready
//   busy       high whenever the unpacker is not idle
//   word_cnt   fully delivered words, wraps silently
// -----------------------------------------------------------------------------
module fifo_unpacker #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  srst,
    input  logic                  fifo_mty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_rd,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int unsigned NUM_BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    // Reject geometries that cannot be split into at least two whole beats.
    if ((DATA_WIDTH % OUT_WIDTH) != 0 || NUM_BEATS < 2) begin : g_bad_geometry
        $error("fifo_unpacker: DATA_WIDTH must be a multiple (>= 2x) of OUT_WIDTH");
    end

    logic [1:0]            state,     state_nxt;
    logic [DATA_WIDTH-1:0] shreg,     shreg_nxt;
    logic [BEAT_W-1:0]     beat,      beat_nxt;
    logic [OUT_WIDTH-1:0]  data_nxt;
    logic                  valid_nxt;
    logic                  last_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  rd_req;

    logic                  hs;
    logic [DATA_WIDTH-1:0] shreg_shift;
    logic [BEAT_W-1:0]     beat_inc;

    assign hs          = out_valid & out_ready;
    assign shreg_shift = shreg >> OUT_WIDTH;
    assign beat_inc    = beat + BEAT_W'(1);
    assign busy        = (state != IDLE);

    // Pop strobe is suppressed during either reset so no word is lost.
    assign fifo_rd = rd_req & arst_n & ~srst;

    // Next-state, datapath and pop-request logic.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        beat_nxt  = beat;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        cnt_nxt   = word_cnt;
        rd_req    = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_mty) begin
                    rd_req    = 1'b1;
                    state_nxt = LOAD;
                end
            end

            // fifo_q is valid this cycle, one cycle after the pop.
            LOAD: begin
                shreg_nxt = fifo_q;
                data_nxt  = fifo_q[OUT_WIDTH-1:0];
                valid_nxt = 1'b1;
                beat_nxt  = '0;
                last_nxt  = 1'b0;
                state_nxt = SEND;
            end

            SEND: begin
                if (hs) begin
                    shreg_nxt = shreg_shift;
                    data_nxt  = shreg_shift[OUT_WIDTH-1:0];
                    beat_nxt  = beat_inc;
                    last_nxt  = (beat_inc == BEAT_W'(NUM_BEATS - 1));
                    if (out_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        cnt_nxt   = word_cnt + CNT_WIDTH'(1);
                        // Chain straight into the next word when one is waiting.
                        if (!fifo_mty) begin
                            rd_req    = 1'b1;
                            state_nxt = LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Synchronous clear wins over everything and discards a partial word.
        if (srst) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            beat_nxt  = '0;
            data_nxt  = '0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            cnt_nxt   = '0;
            rd_req    = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            beat      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            beat      <= beat_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            word_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_unpacker
//   Directed bench for fifo_unpacker (128 -> 4 x 32, 2-bit word counter).
//   A small array-backed fifo model feeds the DUT; inputs are driven and
//   outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_unpacker;

    localparam int unsigned DW = 128;
    localparam int unsigned OW = 32;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          arst_n;
    logic          srst;
    logic          fifo_mty;
    logic [DW-1:0] fifo_q;
    logic          fifo_rd;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    fifo_unpacker #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .srst      (srst),
        .fifo_mty  (fifo_mty),
        .fifo_q    (fifo_q),
        .fifo_rd   (fifo_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fifo model: registered read data, empty when pushes equal pops.
    logic [DW-1:0] mem [0:63];
    int n_push = 0;
    int n_pop  = 0;

    initial fifo_q = '0;

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_q <= mem[n_pop[5:0]];
            n_pop  <= n_pop + 1;
        end
    end

    assign fifo_mty = (n_push == n_pop);

    task automatic push(input logic [DW-1:0] w);
        mem[n_push[5:0]] = w;
        n_push = n_push + 1;
    endtask

    function automatic logic [DW-1:0] ramp_word();
        return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    endfunction

    task automatic test_reset;
        arst_n    = 1'b0;
        srst      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b exp 0", out_last); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (word_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", word_cnt); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %0b exp 0", fifo_rd); end
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [OW-1:0] e;
        push(ramp_word());
        #1;
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL t1_rd got %0b exp 1", fifo_rd); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_load_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_load_busy got %0b exp 1", busy); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            e = 32'h11111111 * 32'(b + 1);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got %0b exp 1", b, out_valid); end
            checks++; if (out_data !== e) begin errors++; $display("FAIL t1_data beat %0d got %h exp %h", b, out_data, e); end
            checks++; if (out_last !== (b == 3)) begin errors++; $display("FAIL t1_last beat %0d got %0b exp %0b", b, out_last, (b == 3)); end
        end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL t1_rd_empty got %0b exp 0", fifo_rd); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_end_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_end_busy got %0b exp 0", busy); end
        checks++; if (word_cnt !== 2'd1) begin errors++; $display("FAIL t1_cnt got %0d exp 1", word_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] w;
        logic [OW-1:0] e;
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 4; b++) w[b*OW +: OW] = 32'hA0000000 | 32'(k << 4) | 32'(b);
            push(w);
        end
        #1;
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL t2_rd_first got %0b exp 1", fifo_rd); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_gap word %0d got %0b exp 0", k, out_valid); end
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                e = 32'hA0000000 | 32'(k << 4) | 32'(b);
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid w%0d b%0d got %0b exp 1", k, b, out_valid); end
                checks++; if (out_data !== e) begin errors++; $display("FAIL t2_data w%0d b%0d got %h exp %h", k, b, out_data, e); end
                checks++; if (out_last !== (b == 3)) begin errors++; $display("FAIL t2_last w%0d b%0d got %0b exp %0b", k, b, out_last, (b == 3)); end
                if (b == 3) begin
                    checks++; if (fifo_rd !== (k < 2)) begin errors++; $display("FAIL t2_rd_chain w%0d got %0b exp %0b", k, fifo_rd, (k < 2)); end
                end
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_end_busy got %0b exp 0", busy); end
        checks++; if (word_cnt !== 2'd0) begin errors++; $display("FAIL t2_cnt got %0d exp 0", word_cnt); end
    endtask

    task automatic test_backpressure;
        push(ramp_word());
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_data !== 32'h11111111) begin errors++; $display("FAIL t3_beat0 got %h exp 11111111", out_data); end
        @(negedge clk);
        checks++; if (out_data !== 32'h22222222) begin errors++; $display("FAIL t3_beat1 got %h exp 22222222", out_data); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_hold_valid cyc %0d got %0b exp 1", i, out_valid); end
            checks++; if (out_data !== 32'h22222222) begin errors++; $display("FAIL t3_hold_data cyc %0d got %h exp 22222222", i, out_data); end
            checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL t3_hold_last cyc %0d got %0b exp 0", i, out_last); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 32'h33333333) begin errors++; $display("FAIL t3_beat2 got %h exp 33333333", out_data); end
        @(negedge clk);
        checks++; if (out_data !== 32'h44444444 || out_last !== 1'b1) begin errors++; $display("FAIL t3_beat3 got %h/%0b exp 44444444/1", out_data, out_last); end
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 32'h44444444) begin
            errors++; $display("FAIL t3_last_hold got %0b/%0b/%h exp 1/1/44444444", out_valid, out_last, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_end_valid got %0b exp 0", out_valid); end
        checks++; if (word_cnt !== 2'd1) begin errors++; $display("FAIL t3_cnt got %0d exp 1", word_cnt); end
    endtask

    task automatic test_empty;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL t4_idle cyc %0d got rd=%0b valid=%0b busy=%0b exp 0/0/0", i, fifo_rd, out_valid, busy);
            end
        end
    endtask

    task automatic test_srst;
        logic [DW-1:0] w;
        logic [OW-1:0] e;
        for (int b = 0; b < 4; b++) w[b*OW +: OW] = 32'hB0000000 | 32'(b);
        push(ramp_word());
        push(w);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_data !== 32'h22222222) begin errors++; $display("FAIL t5_pre got %h exp 22222222", out_data); end
        srst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %0b exp 0", busy); end
        checks++; if (word_cnt !== 2'd0) begin errors++; $display("FAIL t5_cnt got %0d exp 0", word_cnt); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL t5_rd_in_srst got %0b exp 0", fifo_rd); end
        srst = 1'b0;
        #1;
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL t5_rd_after got %0b exp 1", fifo_rd); end
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            e = 32'hB0000000 | 32'(b);
            checks++; if (out_valid !== 1'b1 || out_data !== e || out_last !== (b == 3)) begin
                errors++; $display("FAIL t5_restart b%0d got %0b/%h/%0b exp 1/%h/%0b", b, out_valid, out_data, out_last, e, (b == 3));
            end
        end
        @(negedge clk);
        checks++; if (word_cnt !== 2'd1) begin errors++; $display("FAIL t5_cnt_after got %0d exp 1", word_cnt); end
    endtask

    task automatic test_arst_wrap;
        logic [DW-1:0] w;
        logic [OW-1:0] e;
        int nbeats;
        int cyc;
        push(ramp_word());
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL t6_arst_out got %0b/%0b/%h exp 0/0/0", out_valid, out_last, out_data);
        end
        checks++; if (busy !== 1'b0 || word_cnt !== 2'd0) begin errors++; $display("FAIL t6_arst_state got busy=%0b cnt=%0d exp 0/0", busy, word_cnt); end
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 4; b++) w[b*OW +: OW] = 32'hC0000000 | 32'(k << 8) | 32'(b);
            push(w);
        end
        #1;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL t6_rd_in_arst got %0b exp 0", fifo_rd); end
        @(negedge clk);
        arst_n = 1'b1;
        nbeats = 0;
        cyc    = 0;
        while (nbeats < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                e = 32'hC0000000 | 32'((nbeats / 4) << 8) | 32'(nbeats % 4);
                checks++; if (out_data !== e || out_last !== ((nbeats % 4) == 3)) begin
                    errors++; $display("FAIL t6_beat %0d got %h/%0b exp %h/%0b", nbeats, out_data, out_last, e, ((nbeats % 4) == 3));
                end
                nbeats++;
            end
        end
        checks++; if (nbeats != 20) begin errors++; $display("FAIL t6_timeout beats got %0d exp 20", nbeats); end
        @(negedge clk);
        checks++; if (word_cnt !== 2'd1) begin errors++; $display("FAIL t6_wrap got %0d exp 1", word_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_end_busy got %0b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_srst();
        test_arst_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
